// File: rtl/fetch_pkg.sv
// Shared types and constants for the queued fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// fetch_entry_t is the payload carried by the instruction queue. Its field
// widths are the widths the fetch stage is built with by default. A top that
// overrides ADDR_W or DATA_W must keep them equal to these.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  localparam logic [FETCH_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // Byte distance between sequential instruction words.
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush and an occupancy count.
// Latency: a push is visible at pop_data/empty on the next cycle.
// Backpressure: none internally; the caller must not push when full without popping.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   flush             empties the FIFO; takes priority over push/pop
//   push, push_data   write one entry
//   pop               drop the head entry (pop_data shows the head combinationally)
//   count/empty/full  occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  // A simultaneous pop frees the slot, so push into a full FIFO is fine then.
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && full && !pop && !flush))
    else $error("sync_fifo: push into full FIFO");

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop && empty && !flush))
    else $error("sync_fifo: pop from empty FIFO");

endmodule

// File: rtl/stage_fetch_queued.sv
// Pipelined instruction fetch: issues sequential PCs ahead of decode and queues returned words.
// Latency: response-to-out_valid 1 cycle; redirect-to-first-request 1 cycle.
// Backpressure: out_ready stalls the queue; request credits keep (queued + in flight) <= DEPTH.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   redirect, redirect_pc           load a new PC, flush queue, drop in-flight responses
//   req_valid/req_ready/req_addr    request channel to instruction memory
//   resp_valid/resp_data            in-order response channel (always accepted)
//   out_valid/out_ready             head entry handshake to decode
//   out_instr, out_pc               head entry
//   out_pc_add4/add8/sub4           head PC +4, +8, -4 (wrapping)
module stage_fetch_queued
  import fetch_pkg::*;
#(
  parameter int                ADDR_W          = FETCH_ADDR_W,
  parameter int                DATA_W          = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_add4,
  output logic [ADDR_W-1:0] out_pc_add8,
  output logic [ADDR_W-1:0] out_pc_sub4
);

  localparam int INF_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int QCNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [INF_W-1:0]  inflight;
  logic [INF_W-1:0]  inflight_next;
  logic [INF_W-1:0]  discard;

  logic              req_fire;
  logic              resp_keep;
  logic              q_pop;
  logic [ADDR_W-1:0] resp_pc;

  logic [INF_W-1:0]  pcq_count;
  logic              pcq_empty;
  logic              pcq_full;

  logic [QCNT_W-1:0] q_count;
  logic              q_empty;
  logic              q_full;
  fetch_entry_t      q_push_entry;
  fetch_entry_t      q_head;

  // Credits: every request may only go out if its response is guaranteed a
  // queue slot, counting entries already queued plus all responses pending.
  assign req_valid = !reset && !redirect
                   && (int'(inflight) < MAX_OUTSTANDING)
                   && ((int'(q_count) + int'(inflight)) < DEPTH);
  assign req_addr  = fetch_pc;
  assign req_fire  = req_valid && req_ready;

  // A response arriving in a redirect cycle is stale as well.
  assign resp_keep = resp_valid && (discard == '0) && !redirect;

  assign inflight_next = inflight + INF_W'(req_fire) - INF_W'(resp_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight_next;
      if (redirect) begin
        fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
        // Everything still outstanding after this cycle is stale; pending
        // discards are a subset of that, so this also covers back-to-back
        // redirects.
        discard  <= inflight_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        if (resp_valid && (discard != '0)) discard <= discard - INF_W'(1);
      end
    end
  end

  // Request PCs travel alongside the in-order memory. It is never flushed:
  // stale PCs leave together with their (discarded) responses.
  sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (resp_valid),
    .pop_data  (resp_pc),
    .count     (pcq_count),
    .empty     (pcq_empty),
    .full      (pcq_full)
  );

  assign q_push_entry = '{pc: resp_pc, instr: resp_data};
  // Pops in a redirect cycle are ignored because the whole queue is flushed.
  assign q_pop        = out_valid && out_ready && !redirect;

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (resp_keep),
    .push_data (q_push_entry),
    .pop       (q_pop),
    .pop_data  (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  assign out_valid   = !q_empty;
  assign out_instr   = q_head.instr;
  assign out_pc      = q_head.pc;
  assign out_pc_add4 = q_head.pc + ADDR_W'(PC_STEP);
  assign out_pc_add8 = q_head.pc + ADDR_W'(2 * PC_STEP);
  assign out_pc_sub4 = q_head.pc - ADDR_W'(PC_STEP);

  a_resp_needs_inflight: assert property (@(posedge clk) disable iff (reset)
    resp_valid |-> (inflight != '0))
    else $error("stage_fetch_queued: response with nothing in flight");

  a_inflight_bound: assert property (@(posedge clk) disable iff (reset)
    int'(inflight) <= MAX_OUTSTANDING)
    else $error("stage_fetch_queued: inflight exceeds MAX_OUTSTANDING");

  a_pc_fifo_tracks: assert property (@(posedge clk) disable iff (reset)
    (pcq_count == inflight) && !(resp_valid && pcq_empty)
    && !(req_fire && pcq_full && !resp_valid))
    else $error("stage_fetch_queued: request PC FIFO out of step with inflight");

  a_queue_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(resp_keep && q_full && !q_pop))
    else $error("stage_fetch_queued: push into full instruction queue");

endmodule

// File: tb/tb_stage_fetch_queued.sv
// Self-checking bench for stage_fetch_queued with a queue-level reference model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_stage_fetch_queued;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_add4;
  logic [31:0] out_pc_add8;
  logic [31:0] out_pc_sub4;

  stage_fetch_queued #(
    .ADDR_W          (32),
    .DATA_W          (32),
    .RESET_PC        (32'h8000_0000),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_pc_add4 (out_pc_add4),
    .out_pc_add8 (out_pc_add8),
    .out_pc_sub4 (out_pc_sub4)
  );

  always #5 clk = ~clk;

  // Memory request accepted by the bench memory, tagged with the redirect
  // epoch it was issued in so stale responses can be recognised.
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];      // PCs decode should currently see, head first
  int          epoch = 0;
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1, rr_pct = 0, or_pct = 0;
  logic [31:0] next_req_pc = 32'h8000_0000;
  logic [31:0] deliver_pc = 32'h8000_0000;
  logic        redir_pend = 1'b0;
  logic [31:0] redir_tgt = '0;
  logic        last_out_fire = 1'b0;
  int          tests = 0;
  int          fails = 0;

  // Instruction memory contents: every word is the inverted PC.
  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return ~pc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs after the edge, compare at the falling edge,
  // then advance the model by what the next rising edge will commit.
  task automatic cycle();
    mreq_t ent;
    logic  exp_rv;
    ent = '{addr: '0, due: 0, epoch: -1};
    @(posedge clk);
    cyc++;
    #1;
    req_ready   = ($urandom_range(99) < rr_pct);
    out_ready   = ($urandom_range(99) < or_pct);
    redirect    = redir_pend;
    redirect_pc = redir_tgt;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      resp_valid = 1'b1;
      resp_data  = mem_word(mem_q[0].addr);
    end else begin
      resp_valid = 1'b0;
      resp_data  = $urandom;
    end
    @(negedge clk);

    exp_rv = !redirect && (mem_q.size() < MAX_OUT) && ((exp_q.size() + mem_q.size()) < DEPTH);
    check("req_valid", 32'(req_valid), 32'(exp_rv));
    if (req_valid && exp_rv) check("req_addr", req_addr, next_req_pc);
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    if (out_valid && exp_q.size() > 0) begin
      check("out_pc", out_pc, exp_q[0]);
      check("out_instr", out_instr, mem_word(exp_q[0]));
      check("out_pc_add4", out_pc_add4, exp_q[0] + 32'd4);
      check("out_pc_add8", out_pc_add8, exp_q[0] + 32'd8);
      check("out_pc_sub4", out_pc_sub4, exp_q[0] - 32'd4);
    end

    last_out_fire = out_valid && out_ready && !redirect;
    if (last_out_fire) begin
      check("program_order", out_pc, deliver_pc);
      deliver_pc = deliver_pc + 32'd4;
    end
    if (resp_valid) ent = mem_q.pop_front();
    if (req_valid && req_ready) begin
      mem_q.push_back('{addr: req_addr, due: cyc + int'($urandom_range(lat_max, lat_min)), epoch: epoch});
      next_req_pc = next_req_pc + 32'd4;
    end
    if (redirect) begin
      exp_q.delete();
      epoch++;
      next_req_pc = redir_tgt & ~32'h3;
      deliver_pc  = redir_tgt & ~32'h3;
      redir_pend  = 1'b0;
    end else begin
      if (last_out_fire && exp_q.size() > 0) void'(exp_q.pop_front());
      if (resp_valid && ent.epoch == epoch) exp_q.push_back(ent.addr);
    end
  endtask

  // Redirect in the next cycle; also checks out_valid is low the cycle after.
  task automatic do_redirect(input logic [31:0] tgt);
    redir_pend = 1'b1;
    redir_tgt  = tgt;
    cycle();
    cycle();
    check("out_valid_after_redirect", 32'(out_valid), 32'd0);
  endtask

  task automatic wait_req(input int lim);
    int i;
    i = 0;
    while (!req_valid && i < lim) begin
      cycle();
      i++;
    end
    check("wait_req_valid", 32'(req_valid), 32'd1);
  endtask

  task automatic wait_out(input int lim);
    int i;
    i = 0;
    while (!out_valid && i < lim) begin
      cycle();
      i++;
    end
    check("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  initial begin
    int n;

    // Reset with a redirect asserted: reset must win.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_valid", 32'(req_valid), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    redirect  = 1'b0;
    req_ready = 1'b0;

    // Streaming, 1-cycle memory, decode always ready.
    rr_pct = 100; or_pct = 100; lat_min = 1; lat_max = 1;
    cycle();
    check("first_req_addr", req_addr, 32'h8000_0000);
    wait_out(20);
    check("first_out_pc", out_pc, 32'h8000_0000);
    check("first_out_sub4", out_pc_sub4, 32'h7FFF_FFFC);
    check("first_out_add8", out_pc_add8, 32'h8000_0008);
    check("first_out_instr", out_instr, 32'h7FFF_FFFF);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (last_out_fire) n++;
    end
    check("throughput_10_cycles", 32'(n), 32'd10);

    // Decode stalls: queue fills to DEPTH and requests stop.
    or_pct = 0;
    repeat (10) cycle();
    check("stall_req_valid", 32'(req_valid), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    rr_pct = 0; or_pct = 100;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_out_fire) n++;
    end
    check("stall_drain_count", 32'(n), 32'd4);

    // Latency 3 with two requests in flight, redirect to an unaligned target.
    rr_pct = 100; lat_min = 3; lat_max = 3;
    repeat (8) cycle();
    do_redirect(32'h8000_1002);
    wait_req(10);
    check("redir_req_addr", req_addr, 32'h8000_1000);
    wait_out(20);
    check("redir_out_pc", out_pc, 32'h8000_1000);

    // Redirect while a response arrives and decode is popping.
    lat_min = 1; lat_max = 1;
    repeat (6) cycle();
    do_redirect(32'h8000_2000);
    wait_out(20);
    check("redir2_out_pc", out_pc, 32'h8000_2000);

    // Address wrap at the top of the address space.
    do_redirect(32'hFFFF_FFFC);
    wait_req(10);
    check("wrap_req_addr0", req_addr, 32'hFFFF_FFFC);
    cycle();
    check("wrap_req_addr1", req_addr, 32'h0000_0000);
    wait_out(20);
    check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap_out_add4", out_pc_add4, 32'h0000_0000);
    check("wrap_out_add8", out_pc_add8, 32'h0000_0004);

    // Random handshakes, latencies and redirects against the model.
    for (int blk = 0; blk < 30; blk++) begin
      case ($urandom_range(2))
        0:       rr_pct = 30;
        1:       rr_pct = 70;
        default: rr_pct = 100;
      endcase
      case ($urandom_range(2))
        0:       or_pct = 30;
        1:       or_pct = 70;
        default: or_pct = 100;
      endcase
      lat_min = 1;
      lat_max = int'($urandom_range(4, 1));
      for (int i = 0; i < 50; i++) begin
        if (!redir_pend && $urandom_range(99) < 3) begin
          redir_pend = 1'b1;
          redir_tgt  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                : 32'($urandom);
        end
        cycle();
      end
    end

    // Let outstanding traffic settle before finishing.
    rr_pct = 0; or_pct = 100; lat_max = 1;
    repeat (20) cycle();
    check("final_out_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
